// File: rtl/hpc_pkg.sv
// Shared definitions for the test master: slave register map and FSM encoding.
package hpc_pkg;

   localparam logic [4:0] I1_ADDR = 5'h00;
   localparam logic [4:0] I2_ADDR = 5'h04;
   localparam logic [4:0] O1_ADDR = 5'h08;
   localparam logic [4:0] O2_ADDR = 5'h0C;
   localparam logic [4:0] O3_ADDR = 5'h10;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_RST_HI = 4'd1,
      S_RST_LO = 4'd2,
      S_EN_HI  = 4'd3,
      S_RUN    = 4'd4,
      S_EN_LO  = 4'd5,
      S_SETTLE = 4'd6,
      S_RD1    = 4'd7,
      S_CAP1   = 4'd8,
      S_RD2    = 4'd9,
      S_CAP2   = 4'd10,
      S_RD3    = 4'd11,
      S_CAP3   = 4'd12,
      S_FIN    = 4'd13
   } state_t;

   // Address presented on the bus while in a given state; 0 in strobe-free states.
   function automatic logic [4:0] strobe_addr(input state_t s);
      case (s)
         S_RST_HI, S_RST_LO: strobe_addr = I1_ADDR;
         S_EN_HI, S_EN_LO:   strobe_addr = I2_ADDR;
         S_RD1:              strobe_addr = O1_ADDR;
         S_RD2:              strobe_addr = O2_ADDR;
         S_RD3:              strobe_addr = O3_ADDR;
         default:            strobe_addr = 5'h00;
      endcase
   endfunction

endpackage

// File: rtl/run_timer.sv
// Loadable down-counter used for both the RUN and SETTLE waits; saturates at zero.
module run_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] load_value_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_value_i;
      end else if (enable_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/avalon_test_master.sv
// Avalon-MM master that pulses a slave's reset/enable, waits, then reads back three results.
module avalon_test_master
   import hpc_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   output logic [4:0]       master_address,
   output logic             master_read,
   output logic             master_write,
   output logic [WIDTH-1:0] master_writedata,
   input  logic [WIDTH-1:0] master_readdata,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] run_cycles,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [WIDTH-1:0] res_data_ctr,
   output logic [WIDTH-1:0] res_event_ctr,
   output logic [WIDTH-1:0] res_rand_a,
   output state_t           dbg_state_o
);

   // SETTLE is entered with SETTLE_CYCLES-1 loaded so it lasts exactly SETTLE_CYCLES cycles.
   localparam logic [WIDTH-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES > 0) ? WIDTH'(SETTLE_CYCLES - 1) : '0;

   state_t           state_q, state_d;
   logic             aborted_q, aborted_d;
   logic             busy_q, done_q;
   logic             read_q, write_q;
   logic [4:0]       addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] res1_q, res2_q, res3_q;

   logic             tmr_load, tmr_enable, tmr_zero;
   logic [WIDTH-1:0] tmr_value;

   assign tmr_load   = ((state_q == S_IDLE) && start) || (state_q == S_EN_LO);
   assign tmr_value  = (state_q == S_IDLE) ? run_cycles : SETTLE_LOAD;
   assign tmr_enable = (state_q == S_EN_HI) || (state_q == S_RUN) || (state_q == S_SETTLE);

   run_timer #(.WIDTH(WIDTH)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .load_i       (tmr_load),
      .enable_i     (tmr_enable),
      .load_value_i (tmr_value),
      .zero_o       (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      aborted_d = aborted_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d   = S_RST_HI;
            aborted_d = 1'b0;
         end
         S_RST_HI: state_d = S_RST_LO;
         S_RST_LO: state_d = S_EN_HI;
         // EN_HI already decrements, so RUN sees run_cycles-1 down to 0.
         S_EN_HI, S_RUN: begin
            if (abort) begin
               state_d   = S_EN_LO;
               aborted_d = 1'b1;
            end else if (tmr_zero) begin
               state_d = S_EN_LO;
            end else begin
               state_d = S_RUN;
            end
         end
         S_EN_LO:  state_d = (SETTLE_CYCLES == 0) ? S_RD1 : S_SETTLE;
         S_SETTLE: if (tmr_zero) state_d = S_RD1;
         S_RD1:    state_d = S_CAP1;
         S_CAP1:   state_d = S_RD2;
         S_RD2:    state_d = S_CAP2;
         S_CAP2:   state_d = S_RD3;
         S_RD3:    state_d = S_CAP3;
         S_CAP3:   state_d = S_FIN;
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Bus outputs are decoded from state_d so they are registered and aligned with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         res1_q    <= '0;
         res2_q    <= '0;
         res3_q    <= '0;
      end else begin
         state_q   <= state_d;
         aborted_q <= aborted_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_FIN);
         write_q   <= (state_d inside {S_RST_HI, S_RST_LO, S_EN_HI, S_EN_LO});
         read_q    <= (state_d inside {S_RD1, S_RD2, S_RD3});
         addr_q    <= strobe_addr(state_d);
         wdata_q   <= ((state_d == S_RST_HI) || (state_d == S_EN_HI)) ? WIDTH'(1) : '0;
         if (state_q == S_CAP1) res1_q <= master_readdata;
         if (state_q == S_CAP2) res2_q <= master_readdata;
         if (state_q == S_CAP3) res3_q <= master_readdata;
      end
   end

   assign master_address   = addr_q;
   assign master_read      = read_q;
   assign master_write     = write_q;
   assign master_writedata = wdata_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign aborted          = aborted_q;
   assign res_data_ctr     = res1_q;
   assign res_event_ctr    = res2_q;
   assign res_rand_a       = res3_q;
   assign dbg_state_o      = state_q;

endmodule

// File: doc/avalon_test_master.md
AVALON_TEST_MASTER -- requirements
Module: avalon_test_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the Avalon data width and the width of the result and cycle-count ports.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, the idle cycles after disable before the first read, so clk_tb/clk_dut counters can settle.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous to clk and active-high.
REQ-005 SHALL have port master_address, output, 5, the Avalon word-byte address.
REQ-006 SHALL have ports master_read and master_write, output, 1 each, the Avalon strobes.
REQ-007 SHALL have port master_writedata, output, WIDTH, the Avalon write data.
REQ-008 SHALL have port master_readdata, input, WIDTH, the Avalon read data.
- Slave read latency is fixed at 1 clk.
- There is no waitrequest.
REQ-009 SHALL have ports start and abort, input, 1 each, the control pulses.
REQ-010 SHALL have port run_cycles, input, WIDTH, the number of clk cycles with enable high.
REQ-011 SHALL have ports busy, done and aborted, output, 1 each, the status signals.
REQ-012 SHALL have ports res_data_ctr, res_event_ctr and res_rand_a, output, WIDTH each, the captured read results.

Function
REQ-013 SHALL implement the FSM IDLE -> RST_HI -> RST_LO -> EN_HI -> RUN -> EN_LO -> SETTLE -> RD1 -> CAP1 -> RD2 -> CAP2 -> RD3 -> CAP3 -> FIN -> IDLE.
- Each state lasts one clk, except RUN and SETTLE.
REQ-014 SHALL perform these writes, each with master_write=1 for exactly one cycle:
- RST_HI: address 0x00, data 1.
- RST_LO: address 0x00, data 0.
- EN_HI: address 0x04, data 1.
- EN_LO: address 0x04, data 0.
REQ-015 SHALL latch run_cycles into an internal down-counter on start, stay in RUN for exactly run_cycles cycles, and go from EN_HI directly to EN_LO when run_cycles==0.
REQ-016 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, with no strobes asserted.
REQ-017 SHALL assert master_read=1 for one cycle in RD1, RD2 and RD3, at addresses 0x08, 0x0C and 0x10 respectively.
REQ-018 SHALL capture master_readdata in the following CAPn state, one cycle after the read:
- CAP1 captures into res_data_ctr.
- CAP2 captures into res_event_ctr.
- CAP3 captures into res_rand_a.
REQ-019 SHALL never assert master_read and master_write in the same cycle, and SHALL drive master_address=0 and master_writedata=0 whenever no strobe is asserted.
REQ-020 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-021 SHALL assert busy in every state except IDLE.
REQ-022 SHALL pulse done for exactly one cycle in FIN.
REQ-023 SHALL, on abort asserted in EN_HI or RUN, go to EN_LO on the next cycle and then complete the normal settle and read sequence.
- aborted SHALL be set from that point and held until the next accepted start.
- abort in any other state SHALL be ignored.
REQ-024 SHALL give abort priority over the RUN-counter expiry when both occur in the same cycle, with aborted set.
REQ-025 SHALL clear res_* only on reset, so results hold their values between runs until overwritten in the CAP states.
REQ-026 SHALL implement the RUN counter to full WIDTH, so run_cycles = 2^WIDTH-1 is legal and does not wrap early.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, drive state=IDLE and busy=0 on the next cycle, from any state.
REQ-028 SHALL, on reset, drive master_read, master_write, master_address, master_writedata, done, aborted, all res_* and the counters to 0.
REQ-029 SHALL, if reset occurs mid-run, issue no further Avalon writes, which may leave the slave's enable register at 1; a subsequent start re-pulses the slave reset (RST_HI) and is safe.

Structure
REQ-030 SHALL place in a shared package hpc_pkg:
- the register address constants I1_ADDR=0x00, I2_ADDR=0x04, O1_ADDR=0x08, O2_ADDR=0x0C, O3_ADDR=0x10;
- the FSM state encoding.
REQ-031 SHALL use one sub-module, run_timer, a loadable WIDTH-bit down-counter with load, enable and zero flag, for both the RUN and SETTLE waits.

Verification
REQ-032 SHALL check: run_cycles=5 with a slave model returning 0x11, 0x22, 0x33 -> writes in the order (0x00,1), (0x00,0), (0x04,1), 5 idle cycles, (0x04,0); reads of 0x08, 0x0C, 0x10; res = 0x11, 0x22, 0x33; done one cycle; busy low after.
REQ-033 SHALL check: run_cycles=0 -> EN_LO immediately follows EN_HI; the full read sequence still completes; done=1, aborted=0.
REQ-034 SHALL check: run_cycles=100 with abort at RUN cycle 10 -> EN_LO on the next cycle, aborted=1, done pulses, and res_* are updated.
REQ-035 SHALL check: start pulsed again during RUN -> ignored, with an identical write/read trace and a single done.
REQ-036 SHALL check: reset during SETTLE -> next cycle IDLE with all outputs 0 and no strobes; a new start with run_cycles=3 completes normally.
REQ-037 SHALL check, as an assertion over all tests: master_read and master_write are never both 1, and every strobe lasts exactly 1 cycle.
